subsample_8x8: RTL

// - Encoder-side 4:2:0 chroma subsampler: takes one 8x8 Cb/Cr block streamed row by row.
// - Averages each 2x2 neighbourhood and returns one 4x4 block.
// - Sits between colour conversion and the forward DCT.
// - Exact inverse direction of the decoder's 4x4->8x8 chroma supersampler.

---
 rtl/subsample_8x8.sv | 114 +++++++++++
 1 files changed

// File: rtl/subsample_8x8.sv
// subsample_8x8: 4:2:0 chroma subsampler. One 8x8 Cb/Cr block arrives row by
// row and leaves as a 4x4 block of 2x2 averages.
// Build option: define SUBSAMPLE_ROUND_EN for round-half-up averaging;
// without it the average is an arithmetic floor (sum >>> 2).

// One 2x2 average: two samples from the buffered even row, two from the live odd row.
module subsample_avg #(
  parameter int W = 9
) (
  input  logic signed [W-1:0] s0_i,
  input  logic signed [W-1:0] s1_i,
  input  logic signed [W-1:0] s2_i,
  input  logic signed [W-1:0] s3_i,
  output logic signed [W-1:0] res_o
);
  logic signed [W+1:0] sum, rnd, sh;

  // Two guard bits cover the 4-way sum without overflow.
  assign sum = {{2{s0_i[W-1]}}, s0_i} + {{2{s1_i[W-1]}}, s1_i}
             + {{2{s2_i[W-1]}}, s2_i} + {{2{s3_i[W-1]}}, s3_i};
`ifdef SUBSAMPLE_ROUND_EN
  assign rnd = sum + (W+2)'(2);
`else
  assign rnd = sum;
`endif
  assign sh    = rnd >>> 2;
  // The average of four W-bit samples always fits back into W bits.
  assign res_o = sh[W-1:0];
endmodule

module subsample_8x8 #(
  parameter int W    = 9,
  parameter int CH_W = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [CH_W-1:0]            ch,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0][W-1:0]          in_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0][3:0][W-1:0]     block_out,
  output logic [CH_W-1:0]            out_ch,
  output logic                       err
);
  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [2:0]            row_cnt_q;
  logic [7:0][W-1:0]     buf_q;
  logic [3:0][3:0][W-1:0] blk_q;
  logic [CH_W-1:0]       ch_q;
  logic                  err_q, err_d;
  logic [3:0][W-1:0]     avg_row;
  logic                  xfer, last_row, is_chroma;

  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_HOLD);
  assign xfer      = in_valid && in_ready;
  assign last_row  = (row_cnt_q == 3'd7);
  assign is_chroma = (ch_q == CH_W'(1)) || (ch_q == CH_W'(2));
  assign block_out = blk_q;
  assign out_ch    = ch_q;
  assign err       = err_q;

  // One averager per output column, fed by the buffered even row and the live odd row.
  for (genvar g = 0; g < 4; g++) begin : g_col
    subsample_avg #(.W(W)) u_avg (
      .s0_i  (buf_q[2*g]),
      .s1_i  (buf_q[2*g+1]),
      .s2_i  (in_row[2*g]),
      .s3_i  (in_row[2*g+1]),
      .res_o (avg_row[g])
    );
  end

  // Next state: a chroma block holds its output until taken; a non-chroma block
  // is dropped at row 7 with a one-cycle error pulse.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_COLLECT: if (xfer && last_row) begin
        if (is_chroma) state_d = S_HOLD;
        else           err_d   = 1'b1;
      end
      S_HOLD:    if (out_ready) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // Row accounting, even-row buffering and per-odd-row result capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_COLLECT;
      row_cnt_q <= 3'd0;
      buf_q     <= '0;
      blk_q     <= '0;
      ch_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (xfer) begin
        row_cnt_q <= row_cnt_q + 3'd1;
        if (row_cnt_q == 3'd0) ch_q <= ch;
        if (!row_cnt_q[0]) buf_q <= in_row;
        else               blk_q[row_cnt_q[2:1]] <= avg_row;
      end
    end
  end
endmodule
